// File: rtl/csi2tx_pkt_hdr_gen.sv
// rtl/csi2tx_pkt_hdr_gen.sv - CSI-2 packet header builder: latches {WC,VC,DT}, waits for the external ECC, streams 4 header bytes.

module csi2tx_pkt_hdr_gen #(
    parameter int ECC_LAT = 1
) (
    input  logic        txbyteclkhs,
    input  logic        txbyteclkhs_rst_n,
    input  logic        tinit_start,
    input  logic        hdr_req,
    output logic        hdr_ack,
    input  logic [1:0]  hdr_vc,
    input  logic [5:0]  hdr_dt,
    input  logic [15:0] hdr_wc,
    output logic [23:0] ecc_data_out,
    output logic        ecc_en,
    input  logic [5:0]  ecc_value,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_last,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ECC_WAIT = 2'd1,
        SEND     = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] hdr_r;
    logic [5:0]  ecc_r;
    logic [1:0]  idx;
    logic [1:0]  wait_cnt;
    logic        ecc_done;

    // ECC_LAT is at most 3, so a 2-bit counter reaches it.
    assign ecc_done     = (wait_cnt == 2'(ECC_LAT));
    assign ecc_data_out = hdr_r;

    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        hdr_ack    = 1'b0;
        ecc_en     = 1'b0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_out   = 8'h00;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                hdr_ack = tinit_start;
                if (hdr_req && tinit_start) begin
                    state_nxt = ECC_WAIT;
                end
            end
            ECC_WAIT: begin
                ecc_en = 1'b1;
                if (ecc_done) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                byte_valid = 1'b1;
                byte_last  = (idx == 2'd3);
                case (idx)
                    2'd0:    byte_out = hdr_r[7:0];
                    2'd1:    byte_out = hdr_r[15:8];
                    2'd2:    byte_out = hdr_r[23:16];
                    default: byte_out = {2'b00, ecc_r};
                endcase
                if (byte_ready && (idx == 2'd3)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Link not initialised: abandon whatever is in flight on the next edge.
        if (!tinit_start) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
        if (!txbyteclkhs_rst_n) begin
            hdr_r    <= 24'h0;
            ecc_r    <= 6'h0;
            idx      <= 2'd0;
            wait_cnt <= 2'd0;
        end else if (!tinit_start) begin
            hdr_r    <= 24'h0;
            idx      <= 2'd0;
            wait_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hdr_req) begin
                        hdr_r    <= {hdr_wc, hdr_vc, hdr_dt};
                        wait_cnt <= 2'd0;
                    end
                end
                ECC_WAIT: begin
                    if (ecc_done) begin
                        ecc_r <= ecc_value;
                        idx   <= 2'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                SEND: begin
                    // Wraps back to 0 after the ECC byte, ready for the next header.
                    if (byte_ready) begin
                        idx <= idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
